keypad_event_scanner: RTL

//  Parametrised ROWSxCOLS matrix keypad scanner for the board I/O layer: drives active-low columns,

---
 rtl/keypad_event_scanner.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_event_scanner.sv
// Matrix keypad scanner: drives active-low columns, samples active-low rows,
// debounces press and release per scan frame, queues one code per press.
// Ports: clock, reset_n (sync, active low), linhas (rows in), colunas (cols out),
//   key_code/key_valid/key_ready (show-ahead FIFO head), key_held, fifo_count,
//   overflow (sticky dropped-press flag).
module keypad_event_scanner #(
  parameter int CLK_FREQ        = 50000000,
  parameter int SCAN_HZ         = 1000,
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int FIFO_DEPTH      = 8,
  localparam int CW = $clog2(ROWS*COLS),
  localparam int NW = $clog2(FIFO_DEPTH+1)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [ROWS-1:0] linhas,
  output logic [COLS-1:0] colunas,
  output logic [CW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            key_held,
  output logic [NW-1:0]   fifo_count,
  output logic            overflow
);

  localparam int DWELL = CLK_FREQ / SCAN_HZ;
  localparam int KEYS  = ROWS * COLS;
  localparam int DW    = $clog2(DWELL);
  localparam int COLW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNTW  = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } state_t;

  logic [ROWS-1:0] sync1, sync2;
  logic [DW-1:0]   dcnt;
  logic [COLW-1:0] col;
  logic [KEYS-1:0] acc, frame_map;
  logic            sample, frame_end;
  logic            hit, trk_present;
  logic [CW-1:0]   code;

  state_t          state, state_nx;
  logic [CNTW-1:0] cnt, cnt_nx, cnt_inc;
  logic [CW-1:0]   trk, trk_nx;
  logic            push;

  logic [CW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [NW-1:0]   count;
  logic            full, pop, wr;

  assign sample    = (dcnt == DW'(DWELL - 1));
  assign frame_end = sample && (col == COLW'(COLS - 1));
  assign colunas   = ~(COLS'(1) << col);

  // Frame bitmap including the column being sampled this cycle, so the
  // frame-end decision sees the last column without an extra cycle.
  always_comb begin
    frame_map = acc;
    if (sample) begin
      for (int r = 0; r < ROWS; r++) begin
        if (!sync2[r]) frame_map[r*COLS + int'(col)] = 1'b1;
      end
    end
  end

  always_comb begin
    code = '0;
    for (int i = KEYS - 1; i >= 0; i--) begin
      if (frame_map[i]) code = CW'(i);
    end
  end

  assign hit         = |frame_map;
  assign trk_present = frame_map[trk];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
      dcnt  <= '0;
      col   <= '0;
      acc   <= '0;
    end else begin
      sync1 <= linhas;
      sync2 <= sync1;
      if (sample) begin
        dcnt <= '0;
        if (frame_end) begin
          col <= '0;
          acc <= '0;
        end else begin
          col <= col + 1'b1;
          acc <= frame_map;
        end
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      trk   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      trk   <= trk_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    trk_nx   = trk;
    push     = 1'b0;
    if (frame_end) begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            trk_nx = code;
            cnt_nx = CNTW'(1);
            if (DEBOUNCE_FRAMES == 1) begin
              state_nx = HELD;
              push     = 1'b1;
            end else begin
              state_nx = PRESS_CHK;
            end
          end
        end
        PRESS_CHK: begin
          if (!hit) begin
            state_nx = IDLE;
          end else if (code == trk) begin
            cnt_nx = cnt_inc;
            if (cnt_inc == CNTW'(DEBOUNCE_FRAMES)) begin
              state_nx = HELD;
              push     = 1'b1;
            end
          end else begin
            trk_nx = code;
            cnt_nx = CNTW'(1);
          end
        end
        HELD: begin
          if (!trk_present) begin
            cnt_nx = CNTW'(1);
            if (DEBOUNCE_FRAMES == 1) state_nx = IDLE;
            else state_nx = RELEASE_CHK;
          end
        end
        RELEASE_CHK: begin
          if (trk_present) begin
            state_nx = HELD;
          end else begin
            cnt_nx = cnt_inc;
            if (cnt_inc == CNTW'(DEBOUNCE_FRAMES)) state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign key_held = (state == HELD) || (state == RELEASE_CHK);

  assign full       = (count == NW'(FIFO_DEPTH));
  assign key_valid  = (count != '0);
  assign pop        = key_valid && key_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign wr         = push && (!full || pop);
  assign key_code   = key_valid ? mem[rp] : '0;
  assign fifo_count = count;

  always_ff @(posedge clock) begin
    if (wr) mem[wp] <= trk_nx;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (wr && !pop) count <= count + 1'b1;
      else if (!wr && pop) count <= count - 1'b1;
      if (push && !wr) overflow <= 1'b1;
    end
  end

endmodule
